// File: rtl/regfile_pkg.sv
// Shared types and helpers for the multi-port register file and its dump engine.
package regfile_pkg;

    typedef enum logic [1:0] {
        DUMP_IDLE = 2'd0,
        DUMP_LOAD = 2'd1,
        DUMP_SHOW = 2'd2,
        DUMP_DONE = 2'd3
    } dump_state_e;

    typedef enum logic [1:0] {
        RD_ARRAY  = 2'd0,
        RD_ZERO   = 2'd1,
        RD_BYPASS = 2'd2
    } rd_src_e;

    function automatic logic addr_ok(input int unsigned addr, input int unsigned n_register);
        return addr < n_register;
    endfunction

    // Source selection for any read: out-of-range/zero register, same-edge bypass, or array.
    // wr_en must already be the effective (accepted) write enable.
    function automatic rd_src_e rd_mux(
        input int unsigned addr,
        input logic        wr_en,
        input int unsigned wr_addr,
        input int unsigned n_register,
        input logic        zero_reg,
        input logic        bypass
    );
        if (!addr_ok(addr, n_register) || (zero_reg && addr == 0)) begin
            return RD_ZERO;
        end
        if (bypass && wr_en && wr_addr == addr) begin
            return RD_BYPASS;
        end
        return RD_ARRAY;
    endfunction

endpackage

// File: rtl/regfile_multiport_dump_fsm.sv
// Dump sequencer: walks the register index, handshakes each word, pulses done at the end.
module regfile_multiport_dump_fsm
    import regfile_pkg::*;
#(
    parameter int unsigned NB_REG     = 5,
    parameter int unsigned N_REGISTER = 32
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic              ready,
    output logic [NB_REG-1:0] ptr,
    output logic              load_c,
    output logic              valid,
    output logic              last,
    output logic              busy,
    output logic              done
);

    localparam logic [NB_REG-1:0] LAST_PTR = NB_REG'(N_REGISTER - 1);

    dump_state_e       state;
    dump_state_e       state_next;
    logic [NB_REG-1:0] ptr_next;

    // Status flags are registered from the next state so they line up with the state register.
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= DUMP_IDLE;
            ptr   <= '0;
            valid <= 1'b0;
            last  <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            state <= state_next;
            ptr   <= ptr_next;
            valid <= (state_next == DUMP_SHOW);
            last  <= (state_next == DUMP_SHOW) && (ptr_next == LAST_PTR);
            busy  <= (state_next != DUMP_IDLE);
            done  <= (state_next == DUMP_DONE);
        end
    end

    always_comb begin
        state_next = state;
        ptr_next   = ptr;
        load_c     = 1'b0;
        case (state)
            DUMP_IDLE: begin
                if (start) begin
                    state_next = DUMP_LOAD;
                    ptr_next   = '0;
                end
            end
            DUMP_LOAD: begin
                load_c     = 1'b1;
                state_next = DUMP_SHOW;
            end
            DUMP_SHOW: begin
                if (ready) begin
                    if (ptr == LAST_PTR) begin
                        state_next = DUMP_DONE;
                    end else begin
                        ptr_next   = ptr + NB_REG'(1);
                        state_next = DUMP_LOAD;
                    end
                end
            end
            DUMP_DONE: begin
                state_next = DUMP_IDLE;
            end
            default: begin
                state_next = DUMP_IDLE;
            end
        endcase
    end

endmodule

// File: rtl/regfile_multiport.sv
// Decode-stage register bank: N registered read ports, one write port, bypass, zero register, dump stream.
module regfile_multiport
    import regfile_pkg::*;
#(
    parameter int unsigned NB_REG     = 5,
    parameter int unsigned NB_DATA    = 32,
    parameter int unsigned N_REGISTER = 32,
    parameter int unsigned N_RD_PORTS = 2,
    parameter int unsigned ZERO_REG   = 1,
    parameter int unsigned BYPASS     = 1
) (
    input  logic                          i_clock,
    input  logic                          i_reset,
    input  logic                          i_stall,
    input  logic [N_RD_PORTS*NB_REG-1:0]  i_rd_addr,
    output logic [N_RD_PORTS*NB_DATA-1:0] o_rd_data,
    input  logic                          i_wr_en,
    input  logic [NB_REG-1:0]             i_wr_addr,
    input  logic [NB_DATA-1:0]            i_wr_data,
    input  logic                          i_dump_start,
    input  logic                          i_dump_ready,
    output logic                          o_dump_valid,
    output logic [NB_REG-1:0]             o_dump_addr,
    output logic [NB_DATA-1:0]            o_dump_data,
    output logic                          o_dump_last,
    output logic                          o_dump_busy,
    output logic                          o_dump_done
);

    logic [NB_DATA-1:0] regs [N_REGISTER];
    logic               wr_eff_c;
    logic [NB_REG-1:0]  dump_ptr;
    logic               dump_load_c;

    assign wr_eff_c = i_wr_en
                    && addr_ok(32'(i_wr_addr), N_REGISTER)
                    && !((ZERO_REG != 0) && (i_wr_addr == '0));

    // Value a read of addr would capture on this edge, including same-edge write forwarding.
    function automatic logic [NB_DATA-1:0] read_word(input logic [NB_REG-1:0] addr);
        logic [NB_DATA-1:0] word;
        case (rd_mux(32'(addr), wr_eff_c, 32'(i_wr_addr), N_REGISTER, ZERO_REG != 0, BYPASS != 0))
            RD_ZERO:   word = '0;
            RD_BYPASS: word = i_wr_data;
            default:   word = regs[addr];
        endcase
        return word;
    endfunction

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            for (int i = 0; i < int'(N_REGISTER); i++) begin
                regs[i] <= '0;
            end
        end else if (wr_eff_c) begin
            regs[i_wr_addr] <= i_wr_data;
        end
    end

    for (genvar k = 0; k < int'(N_RD_PORTS); k++) begin : g_rd
        logic [NB_DATA-1:0] q;

        always_ff @(posedge i_clock) begin
            if (i_reset) begin
                q <= '0;
            end else if (!i_stall) begin
                q <= read_word(i_rd_addr[k*NB_REG +: NB_REG]);
            end
        end

        assign o_rd_data[k*NB_DATA +: NB_DATA] = q;
    end

    regfile_multiport_dump_fsm #(
        .NB_REG     (NB_REG),
        .N_REGISTER (N_REGISTER)
    ) u_dump_fsm (
        .clock  (i_clock),
        .reset  (i_reset),
        .start  (i_dump_start),
        .ready  (i_dump_ready),
        .ptr    (dump_ptr),
        .load_c (dump_load_c),
        .valid  (o_dump_valid),
        .last   (o_dump_last),
        .busy   (o_dump_busy),
        .done   (o_dump_done)
    );

    // Each dump word is a snapshot taken in its LOAD cycle; it stays stable through SHOW.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            o_dump_data <= '0;
            o_dump_addr <= '0;
        end else if (dump_load_c) begin
            o_dump_data <= read_word(dump_ptr);
            o_dump_addr <= dump_ptr;
        end
    end

endmodule
